pipelined_multiplier: RTL and testbench

Parametrised, elastic successor to the fixed-latency pipelined multiplier. It computes WIDTH x WIDTH products with a per-transaction signedness mode, carries a user tag alongside each operand pair, and uses valid/ready handshakes on both sides with per-stage bubble collapsing. It sits between operand producers (datapath/FSM) and result consumers that may stall, replacing free-running multiplier instances where backpressure or mixed signedness is needed.

---
 rtl/mul_pkg.sv | 39 +++
 rtl/mul_pipe_stage.sv | 58 +++++
 rtl/pipelined_multiplier.sv | 131 +++++++++++++
 tb/tb_pipelined_multiplier.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared mode encoding and operand-extension helper for the elastic multiplier.
package mul_pkg;

    typedef enum logic [1:0] {
        MUL_UU   = 2'b00,
        MUL_SS   = 2'b01,
        MUL_SU   = 2'b10,
        MUL_RSVD = 2'b11
    } mul_mode_e;

    // Widest operand the extension helper supports.
    localparam int MUL_MAX_W = 64;

    function automatic logic mul_a_signed(input mul_mode_e mode);
        return (mode == MUL_SS) || (mode == MUL_SU);
    endfunction

    function automatic logic mul_b_signed(input mul_mode_e mode);
        return (mode == MUL_SS);
    endfunction

    // op holds a w-bit operand zero-padded on the left; fill replicates into
    // every bit from w upwards, giving the 2*w-bit extension in the low bits.
    function automatic logic [2*MUL_MAX_W-1:0] mul_extend(
        input logic [MUL_MAX_W-1:0] op,
        input logic                 fill,
        input int unsigned          w
    );
        logic [2*MUL_MAX_W-1:0] hi_mask;
        logic [2*MUL_MAX_W-1:0] ext;
        hi_mask = {(2*MUL_MAX_W){1'b1}} << w;
        ext     = {{MUL_MAX_W{1'b0}}, op} & ~hi_mask;
        if (fill) begin
            ext = ext | hi_mask;
        end
        return ext;
    endfunction

endpackage

// File: rtl/mul_pipe_stage.sv
// One elastic register slice: holds a valid product/tag pair and accepts a new
// one whenever it is empty or its downstream neighbour is taking the current one.
module mul_pipe_stage #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              up_valid,
    input  logic [DATA_W-1:0] up_data,
    input  logic [TAG_W-1:0]  up_tag,
    output logic              up_ready,
    output logic              dn_valid,
    output logic [DATA_W-1:0] dn_data,
    output logic [TAG_W-1:0]  dn_tag,
    input  logic              dn_ready
);
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [TAG_W-1:0]  tag_q, tag_d;

    always_comb begin
        up_ready = !valid_q || dn_ready;
        valid_d  = valid_q;
        data_d   = data_q;
        tag_d    = tag_q;
        if (up_ready) begin
            valid_d = up_valid;
            if (up_valid) begin
                data_d = up_data;
                tag_d  = up_tag;
            end
        end
        if (flush) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Payload is qualified by valid_q, so it carries no reset.
    always_ff @(posedge clk) begin
        data_q <= data_d;
        tag_q  <= tag_d;
    end

    assign dn_valid = valid_q;
    assign dn_data  = data_q;
    assign dn_tag   = tag_q;

endmodule

// File: rtl/pipelined_multiplier.sv
// Elastic WIDTH x WIDTH multiplier with per-transaction signedness and a tag
// sideband, built from PIPE_STAGES bubble-collapsing valid/ready slices.
module pipelined_multiplier
    import mul_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int PIPE_STAGES = 5,
    parameter int TAG_W       = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             flush,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [WIDTH-1:0]                 in_a,
    input  logic [WIDTH-1:0]                 in_b,
    input  logic [1:0]                       in_mode,
    input  logic [TAG_W-1:0]                 in_tag,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [2*WIDTH-1:0]               out_result,
    output logic [TAG_W-1:0]                 out_tag,
    output logic                             busy,
    output logic [$clog2(PIPE_STAGES+1)-1:0] occupancy
);
    localparam int OCC_W  = $clog2(PIPE_STAGES + 1);
    localparam int PROD_W = 2 * WIDTH;

    mul_mode_e              mode;
    logic [MUL_MAX_W-1:0]   a_wide, b_wide;
    logic [2*MUL_MAX_W-1:0] a_ext_w, b_ext_w;
    logic [PROD_W-1:0]      a_ext, b_ext, product;
    logic                   unused_ext;

    // Reserved mode carries neither signed flag, so it falls through to UU.
    always_comb begin
        mode   = mul_mode_e'(in_mode);
        a_wide = '0;
        b_wide = '0;
        a_wide[WIDTH-1:0] = in_a;
        b_wide[WIDTH-1:0] = in_b;
        a_ext_w = mul_extend(a_wide, mul_a_signed(mode) && in_a[WIDTH-1], WIDTH);
        b_ext_w = mul_extend(b_wide, mul_b_signed(mode) && in_b[WIDTH-1], WIDTH);
        a_ext   = a_ext_w[PROD_W-1:0];
        b_ext   = b_ext_w[PROD_W-1:0];
        product = a_ext * b_ext;
    end

    assign unused_ext = ^{a_ext_w, b_ext_w};

    // Stage 0 captures the product; later stages only move it along.
    for (genvar i = 0; i < PIPE_STAGES; i++) begin : g_stage
        logic              up_valid, up_rdy, dn_valid, dn_rdy;
        logic [PROD_W-1:0] up_data, dn_data;
        logic [TAG_W-1:0]  up_tag, dn_tag;

        if (i == 0) begin : g_head
            assign up_valid = in_valid && !flush;
            assign up_data  = product;
            assign up_tag   = in_tag;
        end else begin : g_body
            assign up_valid = g_stage[i-1].dn_valid;
            assign up_data  = g_stage[i-1].dn_data;
            assign up_tag   = g_stage[i-1].dn_tag;
        end

        if (i == PIPE_STAGES - 1) begin : g_tail
            assign dn_rdy = out_ready;
        end else begin : g_link
            assign dn_rdy = g_stage[i+1].up_rdy;
        end

        mul_pipe_stage #(
            .DATA_W (PROD_W),
            .TAG_W  (TAG_W)
        ) u_stage (
            .clk      (clk),
            .rst_n    (rst_n),
            .flush    (flush),
            .up_valid (up_valid),
            .up_data  (up_data),
            .up_tag   (up_tag),
            .up_ready (up_rdy),
            .dn_valid (dn_valid),
            .dn_data  (dn_data),
            .dn_tag   (dn_tag),
            .dn_ready (dn_rdy)
        );
    end

    logic              last_valid;
    logic [PROD_W-1:0] last_data;
    logic [TAG_W-1:0]  last_tag;
    logic              push, pop;
    logic [OCC_W-1:0]  occ_q, occ_d;

    assign last_valid = g_stage[PIPE_STAGES-1].dn_valid;
    assign last_data  = g_stage[PIPE_STAGES-1].dn_data;
    assign last_tag   = g_stage[PIPE_STAGES-1].dn_tag;

    assign in_ready   = g_stage[0].up_rdy && !flush;
    assign out_valid  = last_valid && !flush;
    // Gating keeps the unreset payload registers invisible until filled.
    assign out_result = last_valid ? last_data : '0;
    assign out_tag    = last_valid ? last_tag : '0;

    always_comb begin
        push  = in_valid && in_ready;
        pop   = out_valid && out_ready;
        occ_d = occ_q;
        if (flush) begin
            occ_d = '0;
        end else if (push && !pop) begin
            occ_d = occ_q + OCC_W'(1);
        end else if (pop && !push) begin
            occ_d = occ_q - OCC_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    assign occupancy = occ_q;
    assign busy      = (occ_q != '0);

endmodule

// File: tb/tb_pipelined_multiplier.sv
// Scoreboard bench for pipelined_multiplier: the driver queues expected results on
// acceptance, a negedge monitor pops and compares whenever a result is consumed.
module tb_pipelined_multiplier;
    localparam int WIDTH       = 16;
    localparam int PIPE_STAGES = 5;
    localparam int TAG_W       = 4;
    localparam int OCC_W       = $clog2(PIPE_STAGES + 1);

    logic                 clk = 1'b0;
    logic                 rst_n, flush, in_valid, in_ready, out_valid, out_ready, busy;
    logic [WIDTH-1:0]     in_a, in_b;
    logic [1:0]           in_mode;
    logic [TAG_W-1:0]     in_tag, out_tag;
    logic [2*WIDTH-1:0]   out_result;
    logic [OCC_W-1:0]     occupancy;

    typedef struct packed {
        logic [2*WIDTH-1:0] res;
        logic [TAG_W-1:0]   tag;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    pipelined_multiplier #(
        .WIDTH       (WIDTH),
        .PIPE_STAGES (PIPE_STAGES),
        .TAG_W       (TAG_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_mode    (in_mode),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tag    (out_tag),
        .busy       (busy),
        .occupancy  (occupancy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: extend per mode into 64-bit integers, multiply, keep 2*WIDTH bits.
    function automatic logic [2*WIDTH-1:0] ref_mul(input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b,
                                                  input logic [1:0] mode);
        longint xa, xb, p;
        xa = longint'(a);
        xb = longint'(b);
        if (mode == 2'b01 || mode == 2'b10) xa = longint'($signed(a));
        if (mode == 2'b01) xb = longint'($signed(b));
        p = xa * xb;
        return p[2*WIDTH-1:0];
    endfunction

    // One clock of stimulus; called at posedge+1, returns at the next posedge+1.
    task automatic drive(input logic v, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [1:0] m, input logic [TAG_W-1:0] t, input logic ordy,
                         input logic fl, input logic [2*WIDTH-1:0] exp_res,
                         output logic acc, output int acc_cyc, output logic rdy,
                         output logic ov, output logic [OCC_W-1:0] occ);
        in_valid = v; in_a = a; in_b = b; in_mode = m; in_tag = t;
        out_ready = ordy; flush = fl;
        @(negedge clk);
        rdy = in_ready; ov = out_valid; occ = occupancy;
        acc = in_valid && in_ready;
        acc_cyc = cyc;
        @(posedge clk);
        if (fl) sb.delete();
        if (acc) sb.push_back('{res: exp_res, tag: t});
        #1;
    endtask

    task automatic send_latency(input string name, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                input logic [1:0] m, input logic [TAG_W-1:0] t,
                                input logic [2*WIDTH-1:0] exp_res);
        logic acc, rdy, ov;
        logic [OCC_W-1:0] occ;
        int ac, lat;
        bit found;
        drive(1'b1, a, b, m, t, 1'b1, 1'b0, exp_res, acc, ac, rdy, ov, occ);
        chk({name, "_accept"}, acc, 1);
        in_valid = 1'b0;
        found = 0;
        lat = -1;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clk);
            if (out_valid) begin
                found = 1;
                lat = cyc - ac;
            end
        end
        chk({name, "_latency"}, lat, PIPE_STAGES);
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        logic acc, rdy, ov;
        logic [OCC_W-1:0] occ;
        int ac;
        for (int k = 0; k < 40 && sb.size() != 0; k++)
            drive(1'b0, '0, '0, 2'b00, '0, 1'b1, 1'b0, '0, acc, ac, rdy, ov, occ);
        chk({name, "_drained"}, sb.size(), 0);
    endtask

    // Monitor: occupancy/ready bookkeeping, stall stability and result ordering.
    logic               held_vld;
    logic [2*WIDTH-1:0] held_res;
    logic [TAG_W-1:0]   held_tag;
    initial begin
        exp_t e;
        held_vld = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                held_vld = 1'b0;
                continue;
            end
            chk("occupancy", occupancy, sb.size());
            chk("busy", busy, sb.size() != 0);
            chk("in_ready", in_ready, !flush && (sb.size() < PIPE_STAGES || out_ready));
            if (flush) chk("flush_out_valid", out_valid, 0);
            if (held_vld && out_valid) begin
                chk("stall_result_stable", out_result, held_res);
                chk("stall_tag_stable", out_tag, held_tag);
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("spurious_output", out_valid, 0);
                end else begin
                    e = sb.pop_front();
                    chk("result", out_result, e.res);
                    chk("tag", out_tag, e.tag);
                end
            end
            held_vld = out_valid && !out_ready;
            held_res = out_result;
            held_tag = out_tag;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic acc, rdy, ov, ordy, fl, v;
        logic [OCC_W-1:0] occ;
        logic [WIDTH-1:0] a, b;
        logic [1:0] m;
        int ac, next, k;
        bit saw_stall;

        rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0;
        in_mode = 2'b00; in_tag = '0; out_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_busy", busy, 0);
        chk("reset_occupancy", occupancy, 0);
        chk("reset_out_result", out_result, 0);
        chk("reset_out_tag", out_tag, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Directed mode corner cases, each with a latency measurement.
        send_latency("uu_max",  16'hFFFF, 16'hFFFF, 2'b00, 4'd3, 32'hFFFE0001);
        send_latency("ss_neg",  16'hFFFF, 16'h0002, 2'b01, 4'd4, 32'hFFFFFFFE);
        send_latency("ss_min",  16'h8000, 16'h8000, 2'b01, 4'd5, 32'h40000000);
        send_latency("su_mix",  16'hFFFF, 16'hFFFF, 2'b10, 4'd6, 32'hFFFF0001);
        send_latency("rsvd_uu", 16'hFFFF, 16'h0002, 2'b11, 4'd7, 32'h0001FFFE);

        // 12-transaction stream with the consumer stalled for cycles 3..10.
        next = 0; k = 0; saw_stall = 0;
        while ((next < 12 || sb.size() != 0) && k < 100) begin
            ordy = !(k >= 3 && k <= 10);
            a = WIDTH'($urandom); b = WIDTH'($urandom); m = 2'($urandom_range(0, 3));
            drive(next < 12, a, b, m, TAG_W'(next), ordy, 1'b0, ref_mul(a, b, m),
                  acc, ac, rdy, ov, occ);
            if (next < 12 && !rdy) begin
                if (!saw_stall) chk("stall_full_occupancy", occ, PIPE_STAGES);
                saw_stall = 1;
            end
            if (acc) next++;
            k++;
        end
        chk("stall_in_ready_dropped", saw_stall, 1);
        chk("stall_all_accepted", next, 12);
        chk("stall_all_returned", sb.size(), 0);

        // Full pipeline, push and pop every cycle.
        for (int j = 0; j < 12; j++) begin
            a = WIDTH'($urandom); b = WIDTH'($urandom); m = 2'($urandom_range(0, 3));
            drive(1'b1, a, b, m, TAG_W'(j), 1'b0, 1'b0, ref_mul(a, b, m), acc, ac, rdy, ov, occ);
            if (occ == OCC_W'(PIPE_STAGES)) break;
        end
        for (int j = 0; j < 10; j++) begin
            a = WIDTH'($urandom); b = WIDTH'($urandom); m = 2'($urandom_range(0, 3));
            drive(1'b1, a, b, m, TAG_W'(j), 1'b1, 1'b0, ref_mul(a, b, m), acc, ac, rdy, ov, occ);
            chk("tput_accept", acc, 1);
            chk("tput_consume", ov, 1);
            chk("tput_occupancy", occ, PIPE_STAGES);
        end
        drain("tput");

        // Flush with three in flight while a new operand is offered.
        for (int j = 0; j < 3; j++) begin
            a = WIDTH'($urandom); b = WIDTH'($urandom);
            drive(1'b1, a, b, 2'b01, TAG_W'(j), 1'b1, 1'b0, ref_mul(a, b, 2'b01), acc, ac, rdy, ov, occ);
        end
        drive(1'b1, 16'h1111, 16'h2222, 2'b00, 4'd9, 1'b1, 1'b1, ref_mul(16'h1111, 16'h2222, 2'b00),
              acc, ac, rdy, ov, occ);
        chk("flush_input_rejected", acc, 0);
        chk("flush_cycle_out_valid", ov, 0);
        chk("flush_occupancy", occupancy, 0);
        chk("flush_busy", busy, 0);
        send_latency("post_flush", 16'h1234, 16'hFF00, 2'b01, 4'd10, ref_mul(16'h1234, 16'hFF00, 2'b01));

        // Randomized traffic with random backpressure and occasional flushes.
        for (int j = 0; j < 400; j++) begin
            v = 1'($urandom_range(0, 1));
            ordy = ($urandom_range(0, 3) != 0);
            fl = ($urandom_range(0, 49) == 0);
            a = WIDTH'($urandom); b = WIDTH'($urandom); m = 2'($urandom_range(0, 3));
            drive(v, a, b, m, TAG_W'($urandom), ordy, fl, ref_mul(a, b, m), acc, ac, rdy, ov, occ);
        end
        drain("random");

        // Asynchronous reset in the middle of a stalled, full stream.
        for (int j = 0; j < 8; j++) begin
            a = WIDTH'($urandom); b = WIDTH'($urandom);
            drive(1'b1, a, b, 2'b00, TAG_W'(j), 1'b0, 1'b0, ref_mul(a, b, 2'b00), acc, ac, rdy, ov, occ);
        end
        chk("pre_reset_out_valid", out_valid, 1);
        #3 rst_n = 1'b0;
        #1;
        sb.delete();
        chk("async_reset_out_valid", out_valid, 0);
        chk("async_reset_busy", busy, 0);
        chk("async_reset_occupancy", occupancy, 0);
        chk("async_reset_out_result", out_result, 0);
        chk("async_reset_out_tag", out_tag, 0);
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        send_latency("post_reset", 16'd7, 16'd6, 2'b00, 4'd1, 32'd42);
        drain("final");

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
